// File: rtl/tmr_recovery_sequencer.sv
// TMR recovery sequencer: capture, hold, reload and resume on a voter fault.
// Define TMR_RETRY_EN to allow bounded re-recovery from RESUME.
module tmr_recovery_sequencer #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic [2:0]  voter_state,
  input  logic [31:0] pc_voted,
  output logic [31:0] pc_restart,
  output logic        core_hold,
  output logic        core_reload,
  output logic        recov_sel,
  output logic [1:0]  fault_core,
  output logic [7:0]  err_count,
  output logic        fatal,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_HOLD,
    S_RELOAD,
    S_RESUME,
    S_FATAL
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("HOLD_CYCLES out of range");
  end
  if (MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_bad_retry
    $error("MAX_RETRY out of range");
  end

  state_t     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       one_hot;
  logic [1:0] fault_idx;
  logic       new_fault;
  logic       re_fault;
  logic       hold_n, reload_n, sel_n;
  logic       fatal_n, busy_n;

`ifdef TMR_RETRY_EN
  localparam logic [3:0] RETRY_LIM = 4'(MAX_RETRY);
  logic [3:0] retry_q, retry_d;
`endif

  assign one_hot = (voter_state == 3'b001) ||
                   (voter_state == 3'b010) ||
                   (voter_state == 3'b100);

  // Encode the single disagreeing core; 3 when not one-hot.
  always_comb begin
    fault_idx = 2'd3;
    case (voter_state)
      3'b001:  fault_idx = 2'd0;
      3'b010:  fault_idx = 2'd1;
      3'b100:  fault_idx = 2'd2;
      default: fault_idx = 2'd3;
    endcase
  end

  // Next-state logic and decode of next-cycle registered outputs.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    new_fault = 1'b0;
    re_fault  = 1'b0;
`ifdef TMR_RETRY_EN
    retry_d   = retry_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (one_hot) begin
          state_d   = S_CAPTURE;
          new_fault = 1'b1;
`ifdef TMR_RETRY_EN
          retry_d   = '0;
`endif
        end else if (voter_state != 3'b000) begin
          state_d = S_FATAL;
        end
      end
      S_CAPTURE: begin
        state_d = S_HOLD;
        hold_d  = '0;
      end
      S_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = S_RELOAD;
        else hold_d = hold_q + 8'd1;
      end
      S_RELOAD: state_d = S_RESUME;
      S_RESUME: begin
`ifdef TMR_RETRY_EN
        if (voter_state == 3'b000) begin
          state_d = S_IDLE;
          retry_d = '0;
        end else if (one_hot && retry_q < RETRY_LIM) begin
          state_d  = S_CAPTURE;
          re_fault = 1'b1;
          retry_d  = retry_q + 4'd1;
        end else begin
          state_d = S_FATAL;
        end
`else
        if (voter_state == 3'b000) state_d = S_IDLE;
        else state_d = S_FATAL;
`endif
      end
      S_FATAL: state_d = S_FATAL;
      default: state_d = S_IDLE;
    endcase

    hold_n   = 1'b0;
    reload_n = 1'b0;
    sel_n    = 1'b0;
    fatal_n  = 1'b0;
    busy_n   = (state_d != S_IDLE);
    unique case (state_d)
      S_CAPTURE, S_HOLD: begin
        hold_n = 1'b1;
        sel_n  = 1'b1;
      end
      S_RELOAD: begin
        hold_n   = 1'b1;
        reload_n = 1'b1;
        sel_n    = 1'b1;
      end
      S_FATAL: begin
        hold_n  = 1'b1;
        fatal_n = 1'b1;
      end
      default: ;
    endcase
  end

  // State, counters and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      pc_restart  <= '0;
      core_hold   <= 1'b0;
      core_reload <= 1'b0;
      recov_sel   <= 1'b0;
      fault_core  <= 2'd3;
      err_count   <= '0;
      fatal       <= 1'b0;
      busy        <= 1'b0;
`ifdef TMR_RETRY_EN
      retry_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      core_hold   <= hold_n;
      core_reload <= reload_n;
      recov_sel   <= sel_n;
      fatal       <= fatal_n;
      busy        <= busy_n;
`ifdef TMR_RETRY_EN
      retry_q     <= retry_d;
`endif
      if (new_fault) pc_restart <= pc_voted;
      if (new_fault || re_fault) begin
        fault_core <= fault_idx;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_tmr_recovery_sequencer.sv
// Bench for tmr_recovery_sequencer: phase-based model checked every cycle,
// plus hand-computed literal checks for the key scenarios.
module tb_tmr_recovery_sequencer;

  localparam int H  = 4;
  localparam int MR = 3;
`ifdef TMR_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_in;
  logic [2:0]  voter_state;
  logic [31:0] pc_voted;
  logic [31:0] pc_restart;
  logic        core_hold, core_reload, recov_sel;
  logic [1:0]  fault_core;
  logic [7:0]  err_count;
  logic        fatal, busy;

  int checks = 0;
  int errors = 0;

  // model: mode 0 idle, 1 recovering, 2 fatal; t = cycles since capture
  int          m_mode, m_t, m_retry, m_err;
  logic [31:0] m_pc;
  logic [1:0]  m_fc;

  tmr_recovery_sequencer #(
    .HOLD_CYCLES(H),
    .MAX_RETRY  (MR)
  ) dut (
    .clk        (clk),
    .rst_in     (rst_in),
    .voter_state(voter_state),
    .pc_voted   (pc_voted),
    .pc_restart (pc_restart),
    .core_hold  (core_hold),
    .core_reload(core_reload),
    .recov_sel  (recov_sel),
    .fault_core (fault_core),
    .err_count  (err_count),
    .fatal      (fatal),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [2:0] v);
    if (v[0]) return 2'd0;
    if (v[1]) return 2'd1;
    return 2'd2;
  endfunction

  task automatic begin_rec(input logic [2:0] v);
    m_fc   = idx_of(v);
    m_err  = (m_err < 255) ? m_err + 1 : 255;
    m_t    = 0;
    m_mode = 1;
  endtask

  task automatic model_edge(input logic r, input logic [2:0] v,
                            input logic [31:0] pc);
    bit oh;
    oh = ($countones(v) == 1);
    if (r) begin
      m_mode = 0; m_t = 0; m_retry = 0;
      m_err = 0; m_pc = '0; m_fc = 2'd3;
    end else if (m_mode == 0) begin
      if (oh) begin
        m_pc = pc; m_retry = 0;
        begin_rec(v);
      end else if (v != 3'b000) begin
        m_mode = 2;
      end
    end else if (m_mode == 1) begin
      if (m_t < H + 2) m_t++;
      else if (v == 3'b000) m_mode = 0;
      else if (RETRY && oh && m_retry < MR) begin
        m_retry++;
        begin_rec(v);
      end else m_mode = 2;
    end
  endtask

  task automatic compare();
    logic e_hold, e_rel, e_sel, e_fat, e_busy;
    e_hold = (m_mode == 2) || (m_mode == 1 && m_t <= H + 1);
    e_rel  = (m_mode == 1 && m_t == H + 1);
    e_sel  = (m_mode == 1 && m_t <= H + 1);
    e_fat  = (m_mode == 2);
    e_busy = (m_mode != 0);
    chk("core_hold",   32'(core_hold),   32'(e_hold));
    chk("core_reload", 32'(core_reload), 32'(e_rel));
    chk("recov_sel",   32'(recov_sel),   32'(e_sel));
    chk("fatal",       32'(fatal),       32'(e_fat));
    chk("busy",        32'(busy),        32'(e_busy));
    chk("pc_restart",  pc_restart,       m_pc);
    chk("fault_core",  32'(fault_core),  32'(m_fc));
    chk("err_count",   32'(err_count),   32'(m_err));
  endtask

  task automatic step(input logic r, input logic [2:0] v,
                      input logic [31:0] pc);
    rst_in = r; voter_state = v; pc_voted = pc;
    @(posedge clk);
    model_edge(r, v, pc);
    @(negedge clk);
    compare();
  endtask

  initial begin
    int lat, hcnt, exp_err;
    logic [2:0] v;
    m_mode = 0; m_t = 0; m_retry = 0; m_err = 0; m_pc = '0; m_fc = 2'd3;

    step(1'b1, 3'b000, 32'h0);
    step(1'b1, 3'b000, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fault_core", 32'(fault_core), 32'd3);
    step(1'b0, 3'b000, 32'h0);

    // single fault on core B; stray flags during HOLD must be ignored
    lat = 0; hcnt = 0;
    for (int n = 1; n <= 12; n++) begin
      if (n == 1) step(1'b0, 3'b010, 32'h40);
      else if (n == 3) step(1'b0, 3'b100, 32'h99);
      else step(1'b0, 3'b000, 32'h0);
      if (core_reload && lat == 0) lat = n;
      if (core_hold) hcnt++;
      if (n == 2) begin
        chk("s1_pc", pc_restart, 32'h40);
        chk("s1_fc", 32'(fault_core), 32'd1);
      end
    end
    chk("s1_reload_latency", lat, H + 2);
    chk("s1_hold_cycles", hcnt, H + 2);
    chk("s1_err", 32'(err_count), 32'd1);
    chk("s1_idle", 32'(busy), 32'd0);

    // no majority -> fatal on the next cycle, sticky until reset
    step(1'b0, 3'b110, 32'h0);
    chk("s2_fatal", 32'(fatal), 32'd1);
    chk("s2_hold", 32'(core_hold), 32'd1);
    for (int n = 0; n < 20; n++) step(1'b0, 3'b000, 32'h0);
    chk("s2_fatal_sticky", 32'(fatal), 32'd1);
    step(1'b1, 3'b000, 32'h0);
    chk("s2_cleared", 32'(fatal), 32'd0);

    // persistent single-core fault
    v = RETRY ? 3'b001 : 3'b100;
    exp_err = RETRY ? MR + 1 : 1;
    for (int n = 0; n < 80 && !fatal; n++)
      step(1'b0, v, 32'h100 + 32'(n));
    chk("s3_fatal", 32'(fatal), 32'd1);
    chk("s3_err", 32'(err_count), 32'(exp_err));
    chk("s3_pc_first", pc_restart, 32'h100);
    step(1'b1, 3'b000, 32'h0);

    // reset during the second HOLD cycle
    step(1'b0, 3'b001, 32'h200);
    step(1'b0, 3'b000, 32'h0);
    step(1'b0, 3'b000, 32'h0);
    step(1'b1, 3'b000, 32'h0);
    chk("s5_busy", 32'(busy), 32'd0);
    chk("s5_hold", 32'(core_hold), 32'd0);
    chk("s5_err", 32'(err_count), 32'd0);
    chk("s5_pc", pc_restart, 32'd0);
    step(1'b0, 3'b001, 32'h300);
    for (int n = 0; n < 8; n++) step(1'b0, 3'b000, 32'h0);
    chk("s5_restart_err", 32'(err_count), 32'd1);
    chk("s5_restart_pc", pc_restart, 32'h300);
    step(1'b1, 3'b000, 32'h0);

    // 260 isolated faults -> saturation at 255
    for (int i = 0; i < 260; i++) begin
      v = 3'b001 << (i % 3);
      step(1'b0, v, 32'(i));
      for (int n = 0; n < 8; n++) step(1'b0, 3'b000, 32'h0);
    end
    chk("s6_err_sat", 32'(err_count), 32'd255);
    chk("s6_no_fatal", 32'(fatal), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmr_recovery_sequencer.md
TMR_RECOVERY_SEQUENCER -- requirements
Module: tmr_recovery_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: number of cycles spent in HOLD; legal range 1-255.
REQ-002 Parameter MAX_RETRY, default 3: number of consecutive re-recoveries allowed before escalating to FATAL; legal range 1-15.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_in  input  1  synchronous, active-high reset.
REQ-005 voter_state  input  3  per-core disagreement flags from the voter: bit0 = core A, bit1 = core B, bit2 = core C; 000 means all cores agree.
REQ-006 pc_voted  input  32  majority-voted PC.
REQ-007 pc_restart  output  32  PC captured at fault detection and used to restart the cores.
REQ-008 core_hold  output  1  stalls all three cores.
REQ-009 core_reload  output  1  single-cycle pulse that forces the cores to load pc_restart.
REQ-010 recov_sel  output  1  routes MemWrite and ReadData to the recovery register (1) or to data memory (0).
REQ-011 fault_core  output  2  index of the last faulty core: 0 = A, 1 = B, 2 = C, 3 = none.
REQ-012 err_count  output  8  total recoveries started; saturates at 255.
REQ-013 fatal  output  1  sticky flag indicating an unrecoverable fault.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 States are IDLE, CAPTURE, HOLD, RELOAD, RESUME and FATAL; all outputs are registered.
REQ-016 IDLE, voter_state = 000: remain in IDLE with all control outputs low.
REQ-017 IDLE, one-hot voter_state: on the next edge, enter CAPTURE and perform all of the following.
- pc_restart <= pc_voted.
- fault_core <= encoded index of the set bit.
- err_count increments, saturating at 255.
- The retry counter is cleared.
REQ-018 IDLE, two or more bits set in voter_state (no majority): enter FATAL on the next edge.
REQ-019 CAPTURE: lasts exactly 1 cycle with core_hold = 1 and recov_sel = 1, then enters HOLD.
REQ-020 HOLD: core_hold = 1 and recov_sel = 1 for exactly HOLD_CYCLES cycles, then enters RELOAD.
REQ-021 RELOAD: lasts 1 cycle with core_reload = 1 and core_hold = 1, then enters RESUME.
REQ-022 RESUME: lasts 1 cycle with core_hold = 0 and recov_sel = 0; voter_state is sampled, then:
- 000: go to IDLE and clear the retry counter.
- One-hot and retry < MAX_RETRY: retry++, go to CAPTURE, keep pc_restart unchanged, update fault_core.
- Any other case: go to FATAL.
REQ-023 voter_state is ignored in CAPTURE, HOLD and RELOAD.
REQ-024 FATAL: fatal = 1, core_hold = 1, recov_sel = 0 and busy = 1; the block remains in FATAL until rst_in.
REQ-025 Latency from a one-hot voter_state in IDLE to the core_reload pulse is HOLD_CYCLES + 2 cycles; from core_reload to core_hold deassertion is 1 cycle.
REQ-026 Once core_hold falls, data memory writes are re-enabled in the same cycle as recov_sel = 0.

Reset
REQ-027 When rst_in = 1 at a clock edge, the block resets as follows.
- State: IDLE.
- Outputs: pc_restart = 0, core_hold = 0, core_reload = 0, recov_sel = 0, fault_core = 3, err_count = 0, fatal = 0, busy = 0.
- Internal: the retry and hold counters are cleared.
REQ-028 Reset in any state, including mid-HOLD and FATAL, takes effect on that edge; rst_in has priority over every transition.

Configuration
REQ-029 Macro TMR_RETRY_EN defined: RESUME behaves exactly as in REQ-022.
REQ-030 Macro TMR_RETRY_EN undefined: the retry counter is absent.
- RESUME with voter_state = 000: go to IDLE.
- RESUME with any other voter_state: go to FATAL.
- MAX_RETRY is ignored.

Verification
REQ-031 Scenario: HOLD_CYCLES = 4, voter_state = 010, pc_voted = 0x40. Required response:
- pc_restart = 0x40 and fault_core = 1.
- core_hold high for 6 cycles; core_reload pulses 6 cycles after detection.
- Return to IDLE with err_count = 1.
REQ-032 Scenario: voter_state = 110 in IDLE. Required response: fatal = 1 and core_hold = 1 on the next cycle, held through 20 further cycles until rst_in.
REQ-033 Scenario: TMR_RETRY_EN defined, MAX_RETRY = 3, voter_state = 001 held constantly. Required response: 4 recoveries (err_count = 4), then FATAL; pc_restart remains the first captured value.
REQ-034 Scenario: TMR_RETRY_EN undefined, voter_state = 100 held constantly. Required response: 1 recovery, then FATAL with err_count = 1.
REQ-035 Scenario: rst_in asserted on cycle 2 of HOLD. Required response: next cycle all outputs at reset values and state IDLE; a new 001 fault restarts the full sequence.
REQ-036 Scenario: 260 isolated single-core faults, each cleared by RESUME. Required response: err_count saturates at 255 and fatal stays 0.
